mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port synchronous memory between the instruction-fetch port (IF) and the
//   load/store port (LS) of the riscv core. Sits between riscv and memory in riscv_top.
//   Grants one requester per cycle, tracks in-flight reads, and routes read data back to the owner.
//   Drives stall/statistics pulses in the stat_* style. LS has priority, bounded by an IF anti-starvation counter.
// PARAMETERS
//   ADDR_W      32  address width
//   DATA_W      32  data width
//   MEM_LAT     1   memory read latency in cycles (>=1); rdata valid MEM_LAT cycles after mem_en
//   STARVE_MAX  4   consecutive IF denials after which IF wins one conflict (>=1)
// PORTS
//   clk            in   1        clock, rising edge
//   rst_n          in   1        asynchronous active-low reset
//   if_req         in   1        IF read request (level; held until if_gnt)
//   if_addr        in   ADDR_W   IF address
//   if_gnt         out  1        IF request accepted this cycle
//   if_rvalid      out  1        IF read data valid
//   if_rdata       out  DATA_W   IF read data
//   ls_req         in   1        LS request (level; held until ls_gnt)
//   ls_we          in   1        1=store, 0=load
//   ls_type        in   3        RW_type (byte/half/word, signedness) passed through
//   ls_addr        in   ADDR_W   LS address
//   ls_wdata       in   DATA_W   store data
//   ls_gnt         out  1        LS request accepted this cycle
//   ls_rvalid      out  1        LS load data valid
//   ls_rdata       out  DATA_W   LS load data
//   mem_en, mem_we out  1        memory access strobe / write enable
//   mem_type       out  3        RW_type to memory
//   mem_addr       out  ADDR_W   memory address;  mem_wdata out DATA_W store data
//   mem_rdata      in   DATA_W   memory read data
//   stat_conflict  out  1        pulse: both requesters active this cycle
//   stat_if_stall  out  1        pulse: if_req high and not granted
// BEHAVIOUR
//   - Grant is combinational from requests and registered state; one grant max per cycle.
//   - Arbitration: only one req -> grant it. Both -> LS, unless starve_cnt==STARVE_MAX, then IF.
//   - starve_cnt (registered, saturating at STARVE_MAX): +1 each cycle if_req && !if_gnt; cleared on if_gnt
//     or when if_req low.
//   - mem_en = if_gnt|ls_gnt; mem_we = ls_gnt&ls_we; mem_addr/type/wdata muxed from winner;
//     IF accesses drive mem_type=3'b010 (word), mem_we=0, mem_wdata=0. With no grant, all mem_* = 0.
//   - Owner pipeline: MEM_LAT-deep shift register of {valid, owner}; pushed each cycle with
//     {read granted, LS?}. A store pushes valid=0 (stores complete at grant, no rvalid).
//   - Output stage: pipeline tail valid&owner=IF -> if_rvalid=1, if_rdata=mem_rdata;
//     owner=LS -> ls_rvalid=1, ls_rdata=mem_rdata. Non-owner rdata is 0, never X.
//   - Latency: grant at cycle t -> rvalid at cycle t+MEM_LAT. Throughput one access per cycle.
//   - Back-to-back reads by alternating owners return in grant order with no bubbles.
//   - Reset (async, any time): starve_cnt=0, owner pipeline cleared; reads in flight are
//     dropped (no rvalid after reset deassertion). While rst_n=0 all outputs are 0.
//   - Requests are not registered: a request dropped before grant is simply lost, no error.
// STRUCTURE
//   - Shared package: RW_type encodings (RW_WORD=3'b010 etc.) and OWNER_IF/OWNER_LS tags.
//   - One sub-module: arb_owner_pipe (parameterised MEM_LAT shift register of {valid,owner}).
//   - Arbitration, starvation counter and muxes stay in the top of this file.
// TESTING
//   1. Reset: hold rst_n=0 with both reqs high -> all outputs 0; release -> LS granted first cycle.
//   2. IF only, if_addr=0x0,0x4,0x8 back-to-back -> if_gnt each cycle, if_rvalid 1 cycle later, in order.
//   3. LS load at 0x100, then store 0x104=0xDEADBEEF -> ls_rvalid once (load only); mem_we=1 on store cycle.
//   4. Both reqs high for 10 cycles, STARVE_MAX=4 -> grants LS,LS,LS,LS,IF, repeating; stat_conflict=1
//      every cycle, stat_if_stall=1 on the 4 LS-granted cycles per period.
//   5. MEM_LAT=3, alternating IF/LS reads -> rvalids land exactly 3 cycles after each grant on correct port.
//   6. Assert rst_n=0 one cycle after a read grant -> no if_rvalid/ls_rvalid after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LS memory port arbiter: RW_type encodings and read-owner tags.
package mem_port_arbiter_pkg;

  localparam int unsigned RW_TYPE_W = 3;

  localparam logic [RW_TYPE_W-1:0] RW_BYTE   = 3'b000;
  localparam logic [RW_TYPE_W-1:0] RW_HALF   = 3'b001;
  localparam logic [RW_TYPE_W-1:0] RW_WORD   = 3'b010;
  localparam logic [RW_TYPE_W-1:0] RW_BYTE_U = 3'b100;
  localparam logic [RW_TYPE_W-1:0] RW_HALF_U = 3'b101;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } owner_tag_t;

endpackage

// File: rtl/mem_port_arbiter_owner_pipe.sv
// Tracks which port owns each in-flight read; the tail lines up with mem_rdata.
module arb_owner_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  owner_tag_t push,
  output owner_tag_t tail
);

  owner_tag_t stage_q [MEM_LAT];

  // Reset drops every in-flight read so nothing returns after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_LAT); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= push;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tail = stage_q[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between IF and LS; LS wins conflicts unless
// IF has been denied STARVE_MAX cycles in a row. Read data is routed back to its owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [DATA_W-1:0]    if_rdata,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [RW_TYPE_W-1:0] ls_type,
  input  logic [ADDR_W-1:0]    ls_addr,
  input  logic [DATA_W-1:0]    ls_wdata,
  output logic                 ls_gnt,
  output logic                 ls_rvalid,
  output logic [DATA_W-1:0]    ls_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [RW_TYPE_W-1:0] mem_type,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 stat_conflict,
  output logic                 stat_if_stall
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q;
  logic             starved;
  owner_tag_t       push_tag;
  owner_tag_t       tail_tag;

  assign starved = (starve_q == CNT_W'(STARVE_MAX));

  // Grants are gated by rst_n so every output is quiet while reset is held.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst_n) begin
      if (ls_req && (!if_req || !starved)) begin
        ls_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Saturating count of consecutive IF denials.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!if_req || if_gnt) begin
      starve_q <= '0;
    end else if (!starved) begin
      starve_q <= starve_q + CNT_W'(1);
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_type  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_type  = ls_type;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_type  = RW_WORD;
      mem_addr  = if_addr;
    end
  end

  assign stat_conflict = rst_n & if_req & ls_req;
  assign stat_if_stall = rst_n & if_req & ~if_gnt;

  // Stores complete at grant, so only reads occupy a pipeline slot.
  always_comb begin
    push_tag.valid = if_gnt | (ls_gnt & ~ls_we);
    push_tag.owner = ls_gnt ? OWNER_LS : OWNER_IF;
  end

  arb_owner_pipe #(
    .MEM_LAT(MEM_LAT)
  ) u_owner_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_tag),
    .tail (tail_tag)
  );

  always_comb begin
    if_rvalid = tail_tag.valid && (tail_tag.owner == OWNER_IF);
    ls_rvalid = tail_tag.valid && (tail_tag.owner == OWNER_LS);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiter instances (MEM_LAT=1 and 3) in front of small memory models.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q [4][$];

  // Instance A (MEM_LAT=1) and B (MEM_LAT=3) signals
  logic        a_if_req, a_if_gnt, a_if_rvalid, a_ls_req, a_ls_we, a_ls_gnt, a_ls_rvalid;
  logic [31:0] a_if_addr, a_if_rdata, a_ls_addr, a_ls_wdata, a_ls_rdata;
  logic [2:0]  a_ls_type, a_mem_type;
  logic        a_mem_en, a_mem_we, a_stat_conflict, a_stat_if_stall;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_if_req, b_if_gnt, b_if_rvalid, b_ls_req, b_ls_we, b_ls_gnt, b_ls_rvalid;
  logic [31:0] b_if_addr, b_if_rdata, b_ls_addr, b_ls_wdata, b_ls_rdata;
  logic [2:0]  b_ls_type, b_mem_type;
  logic        b_mem_en, b_mem_we, b_stat_conflict, b_stat_if_stall;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_type(a_ls_type), .ls_addr(a_ls_addr),
    .ls_wdata(a_ls_wdata), .ls_gnt(a_ls_gnt), .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_type(a_mem_type), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .stat_conflict(a_stat_conflict), .stat_if_stall(a_stat_if_stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_type(b_ls_type), .ls_addr(b_ls_addr),
    .ls_wdata(b_ls_wdata), .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_type(b_mem_type), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .stat_conflict(b_stat_conflict), .stat_if_stall(b_stat_if_stall)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: data for the address presented MEM_LAT edges earlier
  logic [31:0] a_mp;
  logic [31:0] b_mp [3];
  always @(posedge clk) begin
    a_mp    <= a_mem_addr;
    b_mp[0] <= b_mem_addr;
    b_mp[1] <= b_mp[0];
    b_mp[2] <= b_mp[1];
  end
  assign a_mem_rdata = mem_f(a_mp);
  assign b_mem_rdata = mem_f(b_mp[2]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_rd(input int p, input logic [31:0] addr, input int lat);
    exp_t e;
    e.data = mem_f(addr);
    e.due  = cyc + lat;
    q[p].push_back(e);
  endtask

  // Monitor: pop on rvalid, flag missing/unexpected returns, non-owner rdata must be 0
  task automatic mon(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    if (v) begin
      checks++;
      if (q[p].size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid port %0d @cyc %0d: got data %0h expected no rvalid", p, cyc, d);
      end else begin
        e = q[p].pop_front();
        chk($sformatf("rdata_p%0d", p), 64'(d), 64'(e.data));
        chk($sformatf("rlat_p%0d", p), 64'(cyc), 64'(e.due));
      end
    end else begin
      chk($sformatf("idle_rdata_p%0d", p), 64'(d), 64'd0);
      if (q[p].size() != 0 && q[p][0].due <= cyc) begin
        e = q[p].pop_front();
        checks++;
        errors++;
        $display("FAIL missing_rvalid port %0d @cyc %0d: got no rvalid expected data %0h", p, cyc, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_if_rvalid, a_if_rdata);
    mon(1, a_ls_rvalid, a_ls_rdata);
    mon(2, b_if_rvalid, b_if_rdata);
    mon(3, b_ls_rvalid, b_ls_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nif;
    logic exp_if;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    a_if_req = 1'b1; a_if_addr = 32'h1000; a_ls_req = 1'b1; a_ls_we = 1'b0;
    a_ls_type = 3'b010; a_ls_addr = 32'h2000; a_ls_wdata = '0;
    b_if_req = 1'b1; b_if_addr = '0; b_ls_req = 1'b1; b_ls_we = 1'b0;
    b_ls_type = 3'b010; b_ls_addr = '0; b_ls_wdata = '0;

    // Reset held with both requests high: everything quiet
    repeat (2) begin
      @(negedge clk);
      chk("rst_a_if_gnt", 64'(a_if_gnt), 64'd0);
      chk("rst_a_ls_gnt", 64'(a_ls_gnt), 64'd0);
      chk("rst_a_mem_en", 64'(a_mem_en), 64'd0);
      chk("rst_a_mem_addr", 64'(a_mem_addr), 64'd0);
      chk("rst_a_conflict", 64'(a_stat_conflict), 64'd0);
      chk("rst_a_stall", 64'(a_stat_if_stall), 64'd0);
      chk("rst_b_gnt", 64'({b_if_gnt, b_ls_gnt, b_mem_en}), 64'd0);
    end
    b_if_req = 1'b0; b_ls_req = 1'b0;
    tick();
    rst_n = 1'b1;

    // Both high for 10 cycles: LS x4 then IF, repeating; first cycle after release is LS
    nif = 0;
    for (int k = 0; k < 10; k++) begin
      a_ls_addr = 32'h2000 + 32'(4 * k);
      a_if_addr = 32'h1000 + 32'(4 * nif);
      exp_if = ((k % 5) == 4);
      @(negedge clk);
      chk("starve_ls_gnt", 64'(a_ls_gnt), 64'(!exp_if));
      chk("starve_if_gnt", 64'(a_if_gnt), 64'(exp_if));
      chk("starve_conflict", 64'(a_stat_conflict), 64'd1);
      chk("starve_stall", 64'(a_stat_if_stall), 64'(!exp_if));
      chk("starve_mem_addr", 64'(a_mem_addr), 64'(exp_if ? a_if_addr : a_ls_addr));
      if (exp_if) begin
        expect_rd(0, a_if_addr, 1);
        nif++;
      end else begin
        expect_rd(1, a_ls_addr, 1);
      end
      tick();
    end

    // Idle cycle
    a_if_req = 1'b0; a_ls_req = 1'b0;
    @(negedge clk);
    chk("idle_mem_en", 64'(a_mem_en), 64'd0);
    chk("idle_mem_type", 64'(a_mem_type), 64'd0);
    tick();

    // IF-only back-to-back fetches
    for (int k = 0; k < 3; k++) begin
      a_if_req = 1'b1;
      a_if_addr = 32'(4 * k);
      @(negedge clk);
      chk("if_gnt", 64'(a_if_gnt), 64'd1);
      chk("if_stall", 64'(a_stat_if_stall), 64'd0);
      chk("if_mem_type", 64'(a_mem_type), 64'h2);
      chk("if_mem_we", 64'(a_mem_we), 64'd0);
      chk("if_mem_addr", 64'(a_mem_addr), 64'(a_if_addr));
      expect_rd(0, a_if_addr, 1);
      tick();
    end
    a_if_req = 1'b0;

    // LS unsigned-byte load then word store
    a_ls_req = 1'b1; a_ls_we = 1'b0; a_ls_type = 3'b100; a_ls_addr = 32'h100;
    a_ls_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("ld_gnt", 64'(a_ls_gnt), 64'd1);
    chk("ld_mem_we", 64'(a_mem_we), 64'd0);
    chk("ld_mem_type", 64'(a_mem_type), 64'h4);
    expect_rd(1, a_ls_addr, 1);
    tick();
    a_ls_we = 1'b1; a_ls_type = 3'b010; a_ls_addr = 32'h104; a_ls_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st_gnt", 64'(a_ls_gnt), 64'd1);
    chk("st_mem_en", 64'(a_mem_en), 64'd1);
    chk("st_mem_we", 64'(a_mem_we), 64'd1);
    chk("st_mem_addr", 64'(a_mem_addr), 64'h104);
    chk("st_mem_wdata", 64'(a_mem_wdata), 64'hDEAD_BEEF);
    tick();
    a_ls_req = 1'b0; a_ls_we = 1'b0;
    repeat (2) tick();

    // MEM_LAT=3 instance: alternating IF/LS reads
    for (int k = 0; k < 6; k++) begin
      b_if_req  = ((k % 2) == 0);
      b_ls_req  = ((k % 2) == 1);
      b_if_addr = 32'h3000 + 32'(4 * k);
      b_ls_addr = 32'h4000 + 32'(4 * k);
      @(negedge clk);
      chk("lat3_if_gnt", 64'(b_if_gnt), 64'((k % 2) == 0));
      chk("lat3_ls_gnt", 64'(b_ls_gnt), 64'((k % 2) == 1));
      if ((k % 2) == 0) expect_rd(2, b_if_addr, 3);
      else              expect_rd(3, b_ls_addr, 3);
      tick();
    end
    b_if_req = 1'b0; b_ls_req = 1'b0;
    repeat (5) tick();

    // Reads in flight are dropped by a reset asserted one cycle after grant
    a_ls_req = 1'b1; a_ls_addr = 32'h200;
    b_if_req = 1'b1; b_if_addr = 32'h300;
    @(negedge clk);
    chk("rstdrop_a_gnt", 64'(a_ls_gnt), 64'd1);
    chk("rstdrop_b_gnt", 64'(b_if_gnt), 64'd1);
    tick();
    rst_n = 1'b0;
    a_ls_req = 1'b0; b_if_req = 1'b0;
    @(negedge clk);
    chk("rstdrop_a_rvalid", 64'(a_ls_rvalid), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();

    for (int p = 0; p < 4; p++) begin
      chk($sformatf("queue_empty_p%0d", p), 64'(q[p].size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
